// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding muxes, load-use
// hazard detection and a saturating count of the bubbles that hazard inserts.
module id_ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic [1:0]       id_aluop,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [XLEN-1:0]  ex_mem_alu_result,
  input  logic [XLEN-1:0]  wb_write_data,
  output logic             id_ex_valid,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic             id_ex_regwrite,
  output logic             id_ex_memread,
  output logic             id_ex_memwrite,
  output logic             id_ex_memtoreg,
  output logic [1:0]       id_ex_aluop,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [XLEN-1:0]  store_data,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic [1:0]      aluop;
  } stage_t;

  // A bubble zeroes rs1/rs2 too, so the forwarding unit never matches it.
  localparam stage_t           BUBBLE  = stage_t'({$bits(stage_t){1'b0}});
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  stage_t           stage_r;
  stage_t           stage_next_s;
  stage_t           capture_s;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_next_s;
  logic             load_use_s;
  logic [XLEN-1:0]  fwd_a_s;
  logic [XLEN-1:0]  fwd_b_s;

  function automatic logic [XLEN-1:0] fwd_select(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rs_data,
    input logic [XLEN-1:0] ex_mem_val,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] res;
    case (sel)
      2'b10:   res = ex_mem_val;
      2'b01:   res = wb_val;
      2'b00:   res = rs_data;
      default: res = rs_data;
    endcase
    return res;
  endfunction

  // Pack the decoded ID fields into the stage record
  always_comb begin
    capture_s          = BUBBLE;
    capture_s.valid    = id_valid;
    capture_s.rs1      = id_rs1;
    capture_s.rs2      = id_rs2;
    capture_s.rd       = id_rd;
    capture_s.rs1_data = id_rs1_data;
    capture_s.rs2_data = id_rs2_data;
    capture_s.imm      = id_imm;
    capture_s.pc       = id_pc;
    capture_s.regwrite = id_regwrite;
    capture_s.memread  = id_memread;
    capture_s.memwrite = id_memwrite;
    capture_s.memtoreg = id_memtoreg;
    capture_s.alusrc   = id_alusrc;
    capture_s.aluop    = id_aluop;
  end

  // Load in EX whose destination is a source of the instruction in ID
  always_comb begin
    load_use_s = id_valid & stage_r.valid & stage_r.memread &
                 (stage_r.rd != 5'd0) &
                 ((stage_r.rd == id_rs1) | (stage_r.rd == id_rs2));
  end

  // Next-state selection: flush, then stall, then load-use bubble, then capture
  always_comb begin
    stage_next_s      = stage_r;
    bubble_cnt_next_s = bubble_cnt_r;
    if (flush) begin
      stage_next_s = BUBBLE;
    end else if (stall) begin
      stage_next_s = stage_r;
    end else if (load_use_s) begin
      stage_next_s = BUBBLE;
      if (bubble_cnt_r != CNT_MAX) begin
        bubble_cnt_next_s = bubble_cnt_r + CNT_ONE;
      end else begin
        bubble_cnt_next_s = bubble_cnt_r;
      end
    end else begin
      stage_next_s = capture_s;
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_r      <= BUBBLE;
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stage_r      <= stage_next_s;
      bubble_cnt_r <= bubble_cnt_next_s;
    end
  end

  // Forwarding muxes on the registered operands
  always_comb begin
    fwd_a_s = fwd_select(forwardA, stage_r.rs1_data, ex_mem_alu_result, wb_write_data);
    fwd_b_s = fwd_select(forwardB, stage_r.rs2_data, ex_mem_alu_result, wb_write_data);
    if (stage_r.alusrc) begin
      alu_in2 = stage_r.imm;
    end else begin
      alu_in2 = fwd_b_s;
    end
  end

  assign alu_in1        = fwd_a_s;
  assign store_data     = fwd_b_s;
  assign load_use_stall = load_use_s;
  assign bubble_count   = bubble_cnt_r;

  assign id_ex_valid    = stage_r.valid;
  assign id_ex_rs1      = stage_r.rs1;
  assign id_ex_rs2      = stage_r.rs2;
  assign id_ex_rd       = stage_r.rd;
  assign id_ex_regwrite = stage_r.regwrite;
  assign id_ex_memread  = stage_r.memread;
  assign id_ex_memwrite = stage_r.memwrite;
  assign id_ex_memtoreg = stage_r.memtoreg;
  assign id_ex_aluop    = stage_r.aluop;
  assign id_ex_pc       = stage_r.pc;
  assign id_ex_imm      = stage_r.imm;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture, forwarding, load-use bubbles,
// priority, async reset and counter saturation (second instance with CNT_W = 2).
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [1:0]  id_aluop;
  logic        stall, flush;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] ex_mem_alu_result, wb_write_data;

  logic        id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [1:0]  id_ex_aluop;
  logic [31:0] id_ex_pc, id_ex_imm, alu_in1, alu_in2, store_data;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  logic        s_valid, s_regwrite, s_memread, s_memwrite, s_memtoreg;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_aluop;
  logic [31:0] s_pc, s_imm, s_alu_in1, s_alu_in2, s_store_data;
  logic        s_load_use_stall;
  logic [1:0]  s_bubble_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .stall(stall), .flush(flush), .forwardA(forwardA), .forwardB(forwardB),
    .ex_mem_alu_result(ex_mem_alu_result), .wb_write_data(wb_write_data),
    .id_ex_valid(id_ex_valid), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_memtoreg(id_ex_memtoreg),
    .id_ex_aluop(id_ex_aluop), .id_ex_pc(id_ex_pc), .id_ex_imm(id_ex_imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .store_data(store_data),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  id_ex_operand_stage #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .stall(stall), .flush(flush), .forwardA(forwardA), .forwardB(forwardB),
    .ex_mem_alu_result(ex_mem_alu_result), .wb_write_data(wb_write_data),
    .id_ex_valid(s_valid), .id_ex_rs1(s_rs1), .id_ex_rs2(s_rs2), .id_ex_rd(s_rd),
    .id_ex_regwrite(s_regwrite), .id_ex_memread(s_memread),
    .id_ex_memwrite(s_memwrite), .id_ex_memtoreg(s_memtoreg),
    .id_ex_aluop(s_aluop), .id_ex_pc(s_pc), .id_ex_imm(s_imm),
    .alu_in1(s_alu_in1), .alu_in2(s_alu_in2), .store_data(s_store_data),
    .load_use_stall(s_load_use_stall), .bubble_count(s_bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = 32'h0; id_pc = 32'h0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_memtoreg = 1'b0; id_alusrc = 1'b0; id_aluop = 2'b00;
  endtask

  // lw x5, 8(x2)
  task automatic drive_load();
    clear_id();
    id_valid = 1'b1; id_rs1 = 5'd2; id_rd = 5'd5; id_imm = 32'h8; id_pc = 32'h200;
    id_memread = 1'b1; id_memtoreg = 1'b1; id_regwrite = 1'b1; id_alusrc = 1'b1;
  endtask

  // add x7, x1, x5
  task automatic drive_add();
    clear_id();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd5; id_rd = 5'd7; id_pc = 32'h204;
    id_rs1_data = 32'h33; id_rs2_data = 32'h44; id_regwrite = 1'b1; id_aluop = 2'b10;
  endtask

  task automatic do_bubble(input logic [31:0] exp_cnt, input logic [31:0] exp_sat);
    drive_load();
    step();
    drive_add();
    #1;
    chk("bub_lus", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("bub_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("bub_cnt", {16'd0, bubble_count}, exp_cnt);
    chk("bub_sat_cnt", {30'd0, s_bubble_count}, exp_sat);
  endtask

  initial begin
    reset = 1'b1;
    clear_id();
    stall = 1'b0; flush = 1'b0; forwardA = 2'b00; forwardB = 2'b00;
    ex_mem_alu_result = 32'h0; wb_write_data = 32'h0;
    #12;
    reset = 1'b0;
    chk("rst_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("rst_cnt", {16'd0, bubble_count}, 32'd0);

    // plain capture
    clear_id();
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd6;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_imm = 32'h4; id_pc = 32'h100;
    id_regwrite = 1'b1; id_aluop = 2'b10;
    step();
    chk("cap_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("cap_rs1", {27'd0, id_ex_rs1}, 32'd3);
    chk("cap_rs2", {27'd0, id_ex_rs2}, 32'd4);
    chk("cap_rd", {27'd0, id_ex_rd}, 32'd6);
    chk("cap_pc", id_ex_pc, 32'h100);
    chk("cap_aluop", {30'd0, id_ex_aluop}, 32'd2);
    chk("cap_in1", alu_in1, 32'h11);
    chk("cap_in2", alu_in2, 32'h22);
    chk("cap_sd", store_data, 32'h22);

    // forwarding selects
    forwardA = 2'b10; ex_mem_alu_result = 32'hAAAA; wb_write_data = 32'hBBBB;
    #1;
    chk("fwdA_10", alu_in1, 32'hAAAA);
    forwardA = 2'b01;
    #1;
    chk("fwdA_01", alu_in1, 32'hBBBB);
    forwardA = 2'b11;
    #1;
    chk("fwdA_11", alu_in1, 32'h11);
    forwardA = 2'b00;
    id_alusrc = 1'b1;
    step();
    forwardB = 2'b01;
    #1;
    chk("fwdB_imm", alu_in2, 32'h4);
    chk("fwdB_sd01", store_data, 32'hBBBB);
    forwardB = 2'b10;
    #1;
    chk("fwdB_sd10", store_data, 32'hAAAA);
    forwardB = 2'b00;

    // load-use: bubble then capture of the dependent add
    drive_load();
    step();
    chk("ld_memread", {31'd0, id_ex_memread}, 32'd1);
    chk("ld_rd", {27'd0, id_ex_rd}, 32'd5);
    chk("ld_no_lus", {31'd0, load_use_stall}, 32'd0);
    drive_add();
    #1;
    chk("lu_lus", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("lu_bub_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("lu_bub_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("lu_bub_rs2", {27'd0, id_ex_rs2}, 32'd0);
    chk("lu_bub_regwr", {31'd0, id_ex_regwrite}, 32'd0);
    chk("lu_bub_cnt", {16'd0, bubble_count}, 32'd1);
    chk("lu_lus_drop", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("lu_add_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("lu_add_rd", {27'd0, id_ex_rd}, 32'd7);
    chk("lu_add_pc", id_ex_pc, 32'h204);
    chk("lu_add_cnt", {16'd0, bubble_count}, 32'd1);

    // flush beats load-use
    drive_load();
    step();
    drive_add();
    flush = 1'b1;
    #1;
    chk("fl_lus", {31'd0, load_use_stall}, 32'd1);
    step();
    flush = 1'b0;
    chk("fl_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("fl_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("fl_cnt", {16'd0, bubble_count}, 32'd1);

    // stall beats load-use, hazard resolved once stall drops
    drive_load();
    step();
    drive_add();
    stall = 1'b1;
    step();
    step();
    chk("st_rd", {27'd0, id_ex_rd}, 32'd5);
    chk("st_memread", {31'd0, id_ex_memread}, 32'd1);
    chk("st_pc", id_ex_pc, 32'h200);
    chk("st_imm", id_ex_imm, 32'h8);
    chk("st_cnt", {16'd0, bubble_count}, 32'd1);
    stall = 1'b0;
    #1;
    chk("st_lus", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("st_rel_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("st_rel_cnt", {16'd0, bubble_count}, 32'd2);
    chk("st_rel_sat", {30'd0, s_bubble_count}, 32'd2);

    // push the wide counter to 5 (narrow one pins at 3)
    do_bubble(32'd3, 32'd3);
    do_bubble(32'd4, 32'd3);
    do_bubble(32'd5, 32'd3);
    step();
    chk("pre_rst_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("pre_rst_cnt", {16'd0, bubble_count}, 32'd5);

    // async reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("arst_rd", {27'd0, id_ex_rd}, 32'd0);
    chk("arst_rs1", {27'd0, id_ex_rs1}, 32'd0);
    chk("arst_regwr", {31'd0, id_ex_regwrite}, 32'd0);
    chk("arst_pc", id_ex_pc, 32'h0);
    chk("arst_in1", alu_in1, 32'h0);
    chk("arst_in2", alu_in2, 32'h0);
    chk("arst_cnt", {16'd0, bubble_count}, 32'd0);
    chk("arst_lus", {31'd0, load_use_stall}, 32'd0);
    clear_id();
    #2;
    reset = 1'b0;

    // saturation on the CNT_W = 2 instance
    do_bubble(32'd1, 32'd1);
    do_bubble(32'd2, 32'd2);
    do_bubble(32'd3, 32'd3);
    do_bubble(32'd4, 32'd3);
    do_bubble(32'd5, 32'd3);

    // x0 load never creates a hazard
    drive_load();
    id_rd = 5'd0;
    step();
    clear_id();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd3; id_rd = 5'd9;
    #1;
    chk("x0_lus", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("x0_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("x0_rd", {27'd0, id_ex_rd}, 32'd9);
    chk("x0_sat_cnt", {30'd0, s_bubble_count}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the 5-stage RV32I core.
- Registers the decoded instruction fields from ID and presents rs1/rs2 to the forwarding unit.
- Consumes forwardA/forwardB from the forwarding unit to select the ALU operands and store data.
- Detects load-use hazards, inserts bubbles, and counts the bubbles it inserts.

Parameters:
- XLEN, 32, datapath width in bits.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  5 each  decoded register indices.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm, id_pc  in  XLEN each  immediate and PC.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc  in  1 each  control bits.
- id_aluop  in  2  ALU control class.
- stall  in  1  global hold, e.g. a memory wait.
- flush  in  1  branch/jump redirect; kills the instruction entering EX.
- forwardA, forwardB  in  2 each  selects from the forwarding unit.
- ex_mem_alu_result  in  XLEN  EX/MEM forwarded value.
- wb_write_data  in  XLEN  MEM/WB forwarded value.
- id_ex_valid  out  1  registered valid.
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered indices (rs1/rs2 feed the forwarding unit).
- id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg  out  1 each  registered control.
- id_ex_aluop  out  2  registered ALU control class.
- id_ex_pc, id_ex_imm  out  XLEN each  registered PC and immediate.
- alu_in1, alu_in2, store_data  out  XLEN each  combinational operand outputs.
- load_use_stall  out  1  combinational; tells PC and IF/ID to hold.
- bubble_count  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Async reset: every registered output is 0, including valid, all control bits, indices, PC, imm, the stored rs data and bubble_count.
- Deassertion takes effect on the next edge.
- load_use_stall = id_valid & id_ex_valid & id_ex_memread & (id_ex_rd != 0) & (id_ex_rd == id_rs1 | id_ex_rd == id_rs2).
- Register update priority each edge:
  1. flush: load bubble.
  2. stall: hold all state, bubble_count unchanged.
  3. load_use_stall: load bubble, bubble_count += 1.
  4. otherwise: capture all id_* inputs; id_ex_valid = id_valid.
- Bubble contents: valid = 0; regwrite/memread/memwrite/memtoreg/alusrc = 0; aluop = 0; rd = rs1 = rs2 = 0; data fields = 0.
  - rs = 0 guarantees the forwarding unit returns 00 for a bubble.
- flush together with load_use_stall: flush wins and bubble_count does not increment.
- stall together with load_use_stall: hold wins and the hazard is re-evaluated when stall drops.
- bubble_count saturates at 2^CNT_W-1; it does not wrap.
- Operand mux (combinational, zero cycles after the register):
  - Select 00: stored rs data.
  - Select 10: ex_mem_alu_result.
  - Select 01: wb_write_data.
  - Select 11: reserved; uses stored rs data.
- alu_in1 = fwdA value.
- alu_in2 = id_ex_alusrc ? id_ex_imm : fwdB value.
- store_data = fwdB value regardless of alusrc.
- Latency: ID inputs appear on id_ex_* one cycle after capture.
- rs1/rs2 indices are stored even for instructions that do not use them; the forwarding unit handles x0.

Test Plan:
1. Reset mid-operation: assert reset asynchronously with id_ex_valid = 1 and bubble_count = 5 -> all outputs read 0 immediately, before any clock edge.
2. Plain capture: id_rs1 = 3, id_rs1_data = 0x11, id_rs2_data = 0x22, forwardA = forwardB = 00, alusrc = 0 -> next cycle id_ex_rs1 = 3, alu_in1 = 0x11, alu_in2 = 0x22.
3. Forwarding select:
   - forwardA = 10 with ex_mem_alu_result = 0xAAAA -> alu_in1 = 0xAAAA.
   - forwardB = 01 with wb_write_data = 0xBBBB and alusrc = 1, imm = 0x4 -> alu_in2 = 0x4, store_data = 0xBBBB.
4. Load-use: lw x5 in EX (memread = 1, rd = 5) while ID holds add using rs2 = 5 -> load_use_stall = 1.
   - Next edge loads a bubble (valid = 0, rd = 0) and bubble_count goes 0 -> 1.
   - On the following edge the add is captured.
5. Priority cases:
   - flush with load_use_stall both asserted -> bubble loaded, bubble_count unchanged.
   - stall with load_use_stall both asserted -> registers hold exact values, no increment.
6. Saturation: CNT_W = 2, force 5 consecutive load-use bubbles -> bubble_count reads 1, 2, 3, 3, 3.
   - x0 load (rd = 0) matching rs1 = 0 -> load_use_stall = 0.
